// File: rtl/ro_measure_ctrl.sv
// Ring-oscillator measurement sequencer: enables the ring, lets it settle,
// counts synchronised rising edges over a fixed gate window and publishes the count.
module ro_measure_ctrl #(
    parameter int CNT_W         = 16,
    parameter int TIMER_W       = 16,
    parameter int SETTLE_CYCLES = 16,
    parameter int GATE_CYCLES   = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       cfg_len,
    input  logic             ro_out,
    output logic [2:0]       ro_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    output logic             overflow
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        MEASURE = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } state_e;

    localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GATE_LOAD   = TIMER_W'(GATE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DRAIN_LOAD  = TIMER_W'(1);

    state_e             state_q;
    logic [TIMER_W-1:0] timer_q;
    logic [2:0]         ro_en_q;
    logic               busy_q;
    logic               done_q;
    logic [CNT_W-1:0]   cnt_q,  cnt_d;
    logic               ovf_q,  ovf_d;
    logic [CNT_W-1:0]   result_q;
    logic               result_valid_q;
    logic               overflow_q;
    logic               s1_q, s2_q, s3_q;
    logic               edge_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= ro_out;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign edge_w = s2_q & ~s3_q;

    // Saturating edge counter; overflow flags an edge seen while already full.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (edge_w) begin
            if (cnt_q == '1) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            ro_en_q        <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            cnt_q          <= '0;
            ovf_q          <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        ro_en_q        <= {1'b1, cfg_len};
                        cnt_q          <= '0;
                        ovf_q          <= 1'b0;
                        result_valid_q <= 1'b0;
                        overflow_q     <= 1'b0;
                        timer_q        <= SETTLE_LOAD;
                        busy_q         <= 1'b1;
                        state_q        <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        ro_en_q        <= '0;
                        busy_q         <= 1'b0;
                        result_valid_q <= 1'b0;
                        state_q        <= IDLE;
                    end else if (timer_q == '0) begin
                        timer_q <= GATE_LOAD;
                        state_q <= MEASURE;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                MEASURE: begin
                    if (abort) begin
                        ro_en_q        <= '0;
                        busy_q         <= 1'b0;
                        result_valid_q <= 1'b0;
                        state_q        <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                        ovf_q <= ovf_d;
                        if (timer_q == '0) begin
                            ro_en_q <= '0;
                            timer_q <= DRAIN_LOAD;
                            state_q <= DRAIN;
                        end else begin
                            timer_q <= timer_q - 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        busy_q         <= 1'b0;
                        result_valid_q <= 1'b0;
                        state_q        <= IDLE;
                    end else if (timer_q == '0) begin
                        done_q         <= 1'b1;
                        result_q       <= cnt_q;
                        result_valid_q <= 1'b1;
                        overflow_q     <= ovf_q;
                        state_q        <= DONE;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ro_en_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ro_en        = ro_en_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_ro_measure_ctrl.sv
// Bench for ro_measure_ctrl: a full-size instance and a narrow, short-gate instance,
// each with a behavioural ring model and a done-driven scoreboard monitor.
module tb_ro_measure_ctrl;

    localparam int unsigned SA = 16;
    localparam int unsigned GA = 1024;
    localparam int unsigned SB = 4;
    localparam int unsigned GB = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        start_a, abort_a, ro_a;
    logic [1:0]  cfg_a;
    logic [2:0]  ro_en_a;
    logic        busy_a, done_a, rv_a, ov_a;
    logic [15:0] result_a;

    logic        start_b, abort_b, ro_b;
    logic [1:0]  cfg_b;
    logic [2:0]  ro_en_b;
    logic        busy_b, done_b, rv_b, ov_b;
    logic [3:0]  result_b;

    ro_measure_ctrl #(
        .CNT_W(16), .TIMER_W(16), .SETTLE_CYCLES(SA), .GATE_CYCLES(GA)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .cfg_len(cfg_a), .ro_out(ro_a), .ro_en(ro_en_a), .busy(busy_a),
        .done(done_a), .result(result_a), .result_valid(rv_a), .overflow(ov_a)
    );

    ro_measure_ctrl #(
        .CNT_W(4), .TIMER_W(8), .SETTLE_CYCLES(SB), .GATE_CYCLES(GB)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .cfg_len(cfg_b), .ro_out(ro_b), .ro_en(ro_en_b), .busy(busy_b),
        .done(done_b), .result(result_b), .result_valid(rv_b), .overflow(ov_b)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Ring model: toggles every half_x clk while enabled, held low when disabled.
    int unsigned half_a = 0, half_b = 0;
    int unsigned ra_cnt = 0, rb_cnt = 0;
    initial begin ro_a = 1'b0; ro_b = 1'b0; end

    always @(negedge clk) begin
        if (!ro_en_a[2]) begin
            ro_a = 1'b0; ra_cnt = 0;
        end else if (half_a != 0) begin
            ra_cnt++;
            if (ra_cnt == half_a) begin ro_a = ~ro_a; ra_cnt = 0; end
        end
        if (!ro_en_b[2]) begin
            ro_b = 1'b0; rb_cnt = 0;
        end else if (half_b != 0) begin
            rb_cnt++;
            if (rb_cnt == half_b) begin ro_b = ~ro_b; rb_cnt = 0; end
        end
    end

    typedef struct {
        logic [15:0] res;
        logic        ov;
        int unsigned cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    always @(negedge clk) begin
        if (done_a === 1'b1) begin
            if (qa.size() == 0) begin
                checks++; failures++;
                $display("FAIL a_unexpected_done: got done=1 expected no done at cycle %0d", cyc);
            end else begin
                ea = qa.pop_front();
                chk("a_result", 32'(result_a), 32'(ea.res));
                chk("a_result_valid", 32'(rv_a), 32'd1);
                chk("a_overflow", 32'(ov_a), 32'(ea.ov));
                chk("a_done_cycle", cyc, ea.cyc);
            end
        end
        if (done_b === 1'b1) begin
            if (qb.size() == 0) begin
                checks++; failures++;
                $display("FAIL b_unexpected_done: got done=1 expected no done at cycle %0d", cyc);
            end else begin
                eb = qb.pop_front();
                chk("b_result", 32'(result_b), 32'(eb.res));
                chk("b_result_valid", 32'(rv_b), 32'd1);
                chk("b_overflow", 32'(ov_b), 32'(eb.ov));
                chk("b_done_cycle", cyc, eb.cyc);
            end
        end
    end

    task automatic wait_until(input int unsigned target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_idle_a();
        int unsigned n = 0;
        while (busy_a && n < 3000) begin @(negedge clk); n++; end
        if (busy_a) begin
            checks++; failures++;
            $display("FAIL a_idle_timeout: got busy=1 expected busy=0 within 3000 cycles");
        end
    endtask

    task automatic wait_idle_b();
        int unsigned n = 0;
        while (busy_b && n < 500) begin @(negedge clk); n++; end
        if (busy_b) begin
            checks++; failures++;
            $display("FAIL b_idle_timeout: got busy=1 expected busy=0 within 500 cycles");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish within 2ms");
        $fatal(1, "timeout");
    end

    int unsigned k;

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; cfg_a = 2'b00;
        start_b = 1'b0; abort_b = 1'b0; cfg_b = 2'b00;
        repeat (3) @(negedge clk);

        chk("rst_ro_en_a", 32'(ro_en_a), 32'd0);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_done_a", 32'(done_a), 32'd0);
        chk("rst_result_a", 32'(result_a), 32'd0);
        chk("rst_valid_a", 32'(rv_a), 32'd0);
        chk("rst_overflow_a", 32'(ov_a), 32'd0);
        chk("rst_ro_en_b", 32'(ro_en_b), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Length 4, ring period 8 clk: 1024/8 = 128 edges.
        half_a = 4;
        k = cyc;
        cfg_a = 2'b11; start_a = 1'b1;
        qa.push_back('{res: 16'd128, ov: 1'b0, cyc: k + SA + GA + 3});
        @(negedge clk);
        start_a = 1'b0; cfg_a = 2'b00;
        chk("t1_ro_en_settle", 32'(ro_en_a), 32'b111);
        chk("t1_busy", 32'(busy_a), 32'd1);
        wait_until(k + 1 + SA + 5);
        chk("t1_ro_en_measure", 32'(ro_en_a), 32'b111);
        wait_until(k + 1 + SA + GA);
        chk("t1_ro_en_drain", 32'(ro_en_a), 32'd0);
        wait_idle_a();
        chk("t1_valid_after", 32'(rv_a), 32'd1);
        chk("t1_ro_en_idle", 32'(ro_en_a), 32'd0);

        // Length sweep with a silent ring.
        half_b = 0;
        for (int unsigned len = 0; len < 3; len++) begin
            k = cyc;
            cfg_b = 2'(len); start_b = 1'b1;
            qb.push_back('{res: 16'd0, ov: 1'b0, cyc: k + SB + GB + 3});
            @(negedge clk);
            start_b = 1'b0;
            chk("t2_ro_en_run", 32'(ro_en_b), 32'({1'b1, 2'(len)}));
            wait_until(k + 1 + SB + 10);
            chk("t2_ro_en_measure", 32'(ro_en_b), 32'({1'b1, 2'(len)}));
            wait_until(k + 1 + SB + GB);
            chk("t2_ro_en_drain", 32'(ro_en_b), 32'd0);
            wait_idle_b();
            chk("t2_ro_en_idle", 32'(ro_en_b), 32'd0);
            @(negedge clk);
        end

        // Narrow counter: 64/4 = 16 edges saturates a 4-bit count at 15.
        half_b = 2;
        k = cyc;
        cfg_b = 2'b11; start_b = 1'b1;
        qb.push_back('{res: 16'd15, ov: 1'b1, cyc: k + SB + GB + 3});
        @(negedge clk);
        start_b = 1'b0;
        wait_idle_b();
        @(negedge clk);

        // Abort on the 10th MEASURE cycle.
        k = cyc;
        cfg_b = 2'b10; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        wait_until(k + 1 + SB + 9);
        abort_b = 1'b1;
        @(negedge clk);
        abort_b = 1'b0;
        chk("t4_busy", 32'(busy_b), 32'd0);
        chk("t4_ro_en", 32'(ro_en_b), 32'd0);
        chk("t4_valid", 32'(rv_b), 32'd0);
        chk("t4_result_kept", 32'(result_b), 32'd15);
        chk("t4_done", 32'(done_b), 32'd0);
        repeat (5) @(negedge clk);
        chk("t4_still_idle", 32'(busy_b), 32'd0);

        // Starts while busy are dropped; cfg changes after start are ignored.
        half_b = 4;
        k = cyc;
        cfg_b = 2'b01; start_b = 1'b1;
        qb.push_back('{res: 16'd8, ov: 1'b0, cyc: k + SB + GB + 3});
        @(negedge clk);
        start_b = 1'b0; cfg_b = 2'b00;
        @(negedge clk);
        chk("t5_ro_en_latched", 32'(ro_en_b), 32'b101);
        wait_until(k + 3);  start_b = 1'b1; @(negedge clk); start_b = 1'b0;
        wait_until(k + 30); start_b = 1'b1; @(negedge clk); start_b = 1'b0;
        wait_until(k + SB + GB + 3);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        chk("t5_start_in_done_ignored", 32'(busy_b), 32'd0);
        @(negedge clk);
        chk("t5_no_restart", 32'(busy_b), 32'd0);
        start_b = 1'b1; abort_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0; abort_b = 1'b0;
        chk("t5_start_abort_busy", 32'(busy_b), 32'd0);
        chk("t5_start_abort_ro_en", 32'(ro_en_b), 32'd0);
        chk("t5_start_abort_valid", 32'(rv_b), 32'd1);

        // Asynchronous reset mid-MEASURE, then a fresh run.
        k = cyc;
        cfg_a = 2'b10; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_until(k + 1 + SA + 100);
        chk("t6_pre_ro_en", 32'(ro_en_a), 32'b110);
        rst_n = 1'b0;
        #1;
        chk("t6_ro_en_a", 32'(ro_en_a), 32'd0);
        chk("t6_busy_a", 32'(busy_a), 32'd0);
        chk("t6_done_a", 32'(done_a), 32'd0);
        chk("t6_result_a", 32'(result_a), 32'd0);
        chk("t6_valid_a", 32'(rv_a), 32'd0);
        chk("t6_overflow_a", 32'(ov_a), 32'd0);
        chk("t6_result_b", 32'(result_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        k = cyc;
        cfg_a = 2'b01; start_a = 1'b1;
        qa.push_back('{res: 16'd128, ov: 1'b0, cyc: k + SA + GA + 3});
        @(negedge clk);
        start_a = 1'b0;
        chk("t6_ro_en_fresh", 32'(ro_en_a), 32'b101);
        wait_idle_a();
        repeat (2) @(negedge clk);

        chk("a_queue_drained", qa.size(), 32'd0);
        chk("b_queue_drained", qb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
